// File: rtl/axi4_sim_mem.sv
// axi4_sim_mem: simulation-side AXI4 slave RAM for the Rocket Chip M_AXI port.
// Word-organised 64-bit memory at MEM_BASE with independent single-outstanding
// read and write channels. Out-of-range beats answer DECERR so software traps
// instead of stalling the bus.
//
// Handshake rule for every channel: a transfer happens on the rising clock edge
// where valid and ready are both 1; a source holds its payload stable while
// valid=1 and ready=0, and ready never depends combinationally on valid.
module axi4_sim_mem #(
    parameter int              DATA_W    = 64,
    parameter int              ID_W      = 5,
    parameter int              ADDR_W    = 64,
    parameter logic [63:0]     MEM_BASE  = 64'h8000_0000,
    parameter int              MEM_WORDS = 65536
) (
    input  logic                clock,
    input  logic                reset,

    input  logic                S_AXI_awvalid,
    output logic                S_AXI_awready,
    input  logic [ID_W-1:0]     S_AXI_awid,
    input  logic [ADDR_W-1:0]   S_AXI_awaddr,
    input  logic [7:0]          S_AXI_awlen,
    input  logic [2:0]          S_AXI_awsize,
    input  logic [1:0]          S_AXI_awburst,

    input  logic                S_AXI_wvalid,
    output logic                S_AXI_wready,
    input  logic [DATA_W-1:0]   S_AXI_wdata,
    input  logic [7:0]          S_AXI_wstrb,
    input  logic                S_AXI_wlast,

    output logic                S_AXI_bvalid,
    input  logic                S_AXI_bready,
    output logic [ID_W-1:0]     S_AXI_bid,
    output logic [1:0]          S_AXI_bresp,

    input  logic                S_AXI_arvalid,
    output logic                S_AXI_arready,
    input  logic [ID_W-1:0]     S_AXI_arid,
    input  logic [ADDR_W-1:0]   S_AXI_araddr,
    input  logic [7:0]          S_AXI_arlen,
    input  logic [2:0]          S_AXI_arsize,
    input  logic [1:0]          S_AXI_arburst,

    output logic                S_AXI_rvalid,
    input  logic                S_AXI_rready,
    output logic [ID_W-1:0]     S_AXI_rid,
    output logic [DATA_W-1:0]   S_AXI_rdata,
    output logic [1:0]          S_AXI_rresp,
    output logic                S_AXI_rlast,

    // FSM state taps for checkers: write {0 idle, 1 data, 2 resp}, read {0 idle, 1 data}
    output logic [1:0]          dbg_wr_state,
    output logic [1:0]          dbg_rd_state
);

    localparam int                IDX_W     = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(MEM_BASE);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS) << 3;
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_DECERR = 2'b11;
    localparam logic [1:0]        BURST_FIXED = 2'b00;

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_DATA = 2'd1} rd_state_e;

    // Backing store; contents survive reset and are preloaded by the bench.
    logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

    // wlast is informational only: the latched beat count ends a write burst.
    logic unused_wlast;
    assign unused_wlast = S_AXI_wlast;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE) && ((a - BASE) < MEM_BYTES);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 3);
    endfunction

    // FIXED repeats the start address; INCR and WRAP both step by the beat size.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [2:0] size,
                                                   input logic [1:0] burst);
        return (burst == BURST_FIXED) ? a : a + (ADDR_W'(1) << size);
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_e          wr_state;
    wr_state_e          wr_next;
    logic [ID_W-1:0]    aw_id_q;
    logic [ADDR_W-1:0]  aw_addr_q;
    logic [7:0]         aw_len_q;
    logic [2:0]         aw_size_q;
    logic [1:0]         aw_burst_q;
    logic [7:0]         w_cnt;
    logic               w_err;
    logic               aw_hs;
    logic               w_hs;
    logic               w_last_beat;

    assign aw_hs       = S_AXI_awvalid && S_AXI_awready;
    assign w_hs        = S_AXI_wvalid && S_AXI_wready;
    assign w_last_beat = (w_cnt == aw_len_q);

    // Write FSM state register.
    always_ff @(posedge clock) begin
        if (reset) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    // Write FSM next-state: address, then len+1 data beats, then one response.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (aw_hs) wr_next = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) wr_next = W_RESP;
            W_RESP:  if (S_AXI_bready) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Write FSM outputs; everything is forced quiet while reset is high.
    always_comb begin
        S_AXI_awready = 1'b0;
        S_AXI_wready  = 1'b0;
        S_AXI_bvalid  = 1'b0;
        S_AXI_bid     = '0;
        S_AXI_bresp   = RESP_OKAY;
        if (!reset) begin
            case (wr_state)
                W_IDLE: S_AXI_awready = 1'b1;
                W_DATA: S_AXI_wready  = 1'b1;
                W_RESP: begin
                    S_AXI_bvalid = 1'b1;
                    S_AXI_bid    = aw_id_q;
                    S_AXI_bresp  = w_err ? RESP_DECERR : RESP_OKAY;
                end
                default: ;
            endcase
        end
    end

    // Write burst bookkeeping: latch the command, then walk beats and track errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            w_cnt      <= '0;
            w_err      <= 1'b0;
        end else if (aw_hs) begin
            aw_id_q    <= S_AXI_awid;
            aw_addr_q  <= S_AXI_awaddr;
            aw_len_q   <= S_AXI_awlen;
            aw_size_q  <= S_AXI_awsize;
            aw_burst_q <= S_AXI_awburst;
            w_cnt      <= '0;
            w_err      <= 1'b0;
        end else if (w_hs) begin
            if (!in_range(aw_addr_q)) w_err <= 1'b1;
            if (!w_last_beat) begin
                w_cnt     <= w_cnt + 8'd1;
                aw_addr_q <= next_addr(aw_addr_q, aw_size_q, aw_burst_q);
            end
        end
    end

    // Byte-enabled RAM write; out-of-range beats are silently dropped.
    always_ff @(posedge clock) begin
        if (w_hs && in_range(aw_addr_q)) begin
            for (int b = 0; b < 8; b++) begin
                if (S_AXI_wstrb[b]) mem[word_idx(aw_addr_q)][8*b +: 8] <= S_AXI_wdata[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_e          rd_state;
    rd_state_e          rd_next;
    logic [ID_W-1:0]    rid_q;
    logic [ADDR_W-1:0]  ar_addr_q;
    logic [7:0]         ar_len_q;
    logic [2:0]         ar_size_q;
    logic [1:0]         ar_burst_q;
    logic [7:0]         r_cnt;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         rresp_q;
    logic               rlast_q;
    logic               ar_hs;
    logic               r_hs;
    logic               r_last_beat;
    logic               r_adv;
    logic               r_load;
    logic [ADDR_W-1:0]  ld_addr;

    assign ar_hs       = S_AXI_arvalid && S_AXI_arready;
    assign r_hs        = S_AXI_rvalid && S_AXI_rready;
    assign r_last_beat = (r_cnt == ar_len_q);
    assign r_adv       = r_hs && !r_last_beat;
    // The output register is refilled on the AR handshake (beat 0) and on every
    // non-final R handshake, so a continuously-ready master sees no bubbles.
    assign r_load      = ar_hs || r_adv;
    assign ld_addr     = ar_hs ? S_AXI_araddr : next_addr(ar_addr_q, ar_size_q, ar_burst_q);

    // Read FSM state register.
    always_ff @(posedge clock) begin
        if (reset) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    // Read FSM next-state: stay in R_DATA until the last beat is accepted.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // Read FSM outputs; payload comes straight from the held output register.
    always_comb begin
        S_AXI_arready = 1'b0;
        S_AXI_rvalid  = 1'b0;
        S_AXI_rid     = '0;
        S_AXI_rdata   = '0;
        S_AXI_rresp   = RESP_OKAY;
        S_AXI_rlast   = 1'b0;
        if (!reset) begin
            S_AXI_arready = (rd_state == R_IDLE);
            S_AXI_rvalid  = (rd_state == R_DATA);
            S_AXI_rid     = rid_q;
            S_AXI_rdata   = rdata_q;
            S_AXI_rresp   = rresp_q;
            S_AXI_rlast   = rlast_q;
        end
    end

    // Read burst bookkeeping: beat address, counter and the rlast flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            rid_q      <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            r_cnt      <= '0;
            rlast_q    <= 1'b0;
        end else if (ar_hs) begin
            rid_q      <= S_AXI_arid;
            ar_addr_q  <= S_AXI_araddr;
            ar_len_q   <= S_AXI_arlen;
            ar_size_q  <= S_AXI_arsize;
            ar_burst_q <= S_AXI_arburst;
            r_cnt      <= '0;
            rlast_q    <= (S_AXI_arlen == 8'd0);
        end else if (r_adv) begin
            ar_addr_q  <= ld_addr;
            r_cnt      <= r_cnt + 8'd1;
            rlast_q    <= ((r_cnt + 8'd1) == ar_len_q);
        end
    end

    // Synchronous RAM read into the output register; a write to the same word
    // on the same edge is not visible here (read-first).
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else if (r_load) begin
            if (in_range(ld_addr)) begin
                rdata_q <= mem[word_idx(ld_addr)];
                rresp_q <= RESP_OKAY;
            end else begin
                rdata_q <= '0;
                rresp_q <= RESP_DECERR;
            end
        end
    end

    assign dbg_wr_state = wr_state;
    assign dbg_rd_state = rd_state;

endmodule

// File: doc/axi4_sim_mem.md
Name: axi4_sim_mem

Overview:
Simulation-side AXI4 slave memory that consumes the Rocket Chip wrapper's M_AXI memory master port in the Verilator testbench. It provides a byte-addressable, word-organised RAM at a fixed base address. It supports INCR/FIXED bursts, with one outstanding read and one outstanding write handled by independent channels. Out-of-range accesses complete with DECERR so the core traps instead of hanging the simulation.

Parameters:
DATA_W, 64, data width in bits; fixed at 64, with 8 strobe bits
ID_W, 5, AXI ID width
ADDR_W, 64, AXI address width
MEM_BASE, 64'h8000_0000, first byte address served
MEM_WORDS, 65536, depth in 64-bit words (512 KiB); must be a power of two

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
S_AXI_awvalid  in  1  write address valid
S_AXI_awready  out  1  write address ready
S_AXI_awid  in  ID_W  write ID
S_AXI_awaddr  in  ADDR_W  write byte address
S_AXI_awlen  in  8  beats minus one
S_AXI_awsize  in  3  log2 bytes per beat (0..3)
S_AXI_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP (handled as INCR)
S_AXI_wvalid  in  1  write data valid
S_AXI_wready  out  1  write data ready
S_AXI_wdata  in  DATA_W  write data
S_AXI_wstrb  in  8  byte enables
S_AXI_wlast  in  1  last beat (ignored; the beat count governs)
S_AXI_bvalid  out  1  write response valid
S_AXI_bready  in  1  write response ready
S_AXI_bid  out  ID_W  response ID
S_AXI_bresp  out  2  00 OKAY, 11 DECERR
S_AXI_arvalid  in  1  read address valid
S_AXI_arready  out  1  read address ready
S_AXI_arid  in  ID_W  read ID
S_AXI_araddr  in  ADDR_W  read byte address
S_AXI_arlen  in  8  beats minus one
S_AXI_arsize  in  3  log2 bytes per beat
S_AXI_arburst  in  2  burst type
S_AXI_rvalid  out  1  read data valid
S_AXI_rready  in  1  read data ready
S_AXI_rid  out  ID_W  read ID
S_AXI_rdata  out  DATA_W  read data
S_AXI_rresp  out  2  00 OKAY, 11 DECERR
S_AXI_rlast  out  1  last read beat

The lock, cache, prot and qos signals are not ports; the instantiator leaves them unconnected.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous and active-high.
- Values during reset: awready=0, arready=0, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=00, rresp=00, bid=0, rid=0, rdata=0.
- After reset: both FSMs go to IDLE. Any in-flight burst is dropped without a response. RAM contents are retained, with no reset or initialisation in RTL; the bench preloads the RAM hierarchically.
- Address decode: a beat is in range iff MEM_BASE <= addr < MEM_BASE + 8*MEM_WORDS. The word index is (addr - MEM_BASE) >> 3.
- Beat address: FIXED keeps the start address for every beat. INCR and WRAP add (1 << size) per beat, with a 64-bit wrap-around.
- Write FSM, W_IDLE: awready=1. On aw handshake, latch id, addr, len, size and burst; clear the error flag and the beat counter; go to W_DATA.
- Write FSM, W_DATA: wready=1. On each w handshake:
  - If the beat is in range, write the bytes whose wstrb bit is set; otherwise drop the beat and set the error flag.
  - On the beat where counter==len, go to W_RESP; otherwise increment the counter and advance the address.
- Write FSM, W_RESP: bvalid=1, bid=latched id, bresp = error ? 11 : 00. On bready, go to W_IDLE.
- Read FSM, R_IDLE: arready=1. On ar handshake, latch the fields and go to R_DATA.
- Read FSM, R_DATA: the first rvalid appears in the cycle after the AR handshake. The RAM is read synchronously and the output register holds rdata, rid, rresp and rlast stable while rvalid=1 and rready=0.
  - rlast=1 iff counter==len.
  - An out-of-range beat gives rdata=0 and rresp=11 for that beat only.
  - On an r handshake with rready continuously high, the next beat follows in the next cycle with no bubble.
  - On a handshake of the last beat, go to R_IDLE; arready is 1 in the following cycle.
- Read and write are independent: an AR and an AW may be accepted in the same cycle.
- Same-word read and write in one cycle: the read returns the pre-write data (read-first).
- A 256-beat burst (len=255) must complete with a counter width of 8 and no overflow.

Test Plan:
- Reset, then AW addr=0x8000_0000, len=0, size=3, wdata=0x1122334455667788, wstrb=FF; AR same address -> bresp=00, bid=awid; rdata=0x1122334455667788, rlast=1, first rvalid one cycle after arready&arvalid.
- INCR write len=7 at 0x8000_0100 with data k; AR len=7 with rready toggling every cycle -> 8 beats with data 0..7, rlast only on beat 7, rdata held stable while stalled.
- Write 0xFFFF_FFFF_FFFF_FFFF then wstrb=0x0F with wdata=0 at the same address -> read returns 0xFFFF_FFFF_0000_0000.
- AR addr=0x7FFF_FFF8, len=1 -> beat 0 rresp=11 rdata=0, beat 1 (0x8000_0000) rresp=00; AW at 0x1000 -> bresp=11 and the RAM is unchanged.
- Assert reset during beat 3 of an 8-beat read and mid-write -> rvalid=0, bvalid=0 in the reset cycle; after release arready=1, awready=1; beats written before reset persist.
- Simultaneous AW and AR to the same word with wvalid in the read-issue cycle -> read returns the old data, bresp=00, and both channels complete.
